// File: rtl/uart_rx_oversampled.sv
// UART receiver with 16x oversampling, selectable baud, optional even/odd parity
// and stop-bit framing check. Config is latched at each start edge.
module uart_rx_oversampled #(
    parameter int n        = 8,
    parameter int CLK_FREQ = 100_000_000,
    parameter int OVS      = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [2:0]   baud_rateSel,
    input  logic         include_parity,
    input  logic         parity_type,
    input  logic         Rx,
    output logic [n-1:0] recive_msg_content,
    output logic         valid,
    output logic         correct,
    output logic         framing_err,
    output logic         Rx_idle
);
    localparam int DIV_W  = 16;
    localparam int TICK_W = $clog2(OVS);
    localparam int BIT_W  = $clog2(n + 1);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(n - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel);
        int baud;
        case (sel)
            3'd0:    baud = 1200;
            3'd1:    baud = 2400;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        // rounded divide so e.g. 100 MHz / (115200*16) gives 54
        return DIV_W'((CLK_FREQ + (baud * OVS) / 2) / (baud * OVS));
    endfunction

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, rx_prev_q;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [n-1:0]        shift_q, shift_d;
    logic [2:0]          sel_q, sel_d;
    logic                par_en_q, par_en_d, par_type_q, par_type_d;
    logic                par_ok_q, par_ok_d;
    logic [n-1:0]        data_q, data_d;
    logic                valid_q, valid_d, correct_q, correct_d;
    logic                ferr_q, ferr_d, idle_q, idle_d;
    logic                rx_s, tick_s;
    logic [DIV_W-1:0]    div_s;

    assign rx_s   = sync2_q;
    assign div_s  = baud_div(sel_q);
    assign tick_s = (div_cnt_q == div_s - 1'b1);

    // Next-state logic for the tick generator, frame FSM and outputs
    always_comb begin
        state_d    = state_q;
        div_cnt_d  = tick_s ? {DIV_W{1'b0}} : div_cnt_q + 1'b1;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        sel_d      = sel_q;
        par_en_d   = par_en_q;
        par_type_d = par_type_q;
        par_ok_d   = par_ok_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        correct_d  = correct_q;
        ferr_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    sel_d      = baud_rateSel;
                    par_en_d   = include_parity;
                    par_type_d = parity_type;
                    div_cnt_d  = {DIV_W{1'b0}};
                    tick_cnt_d = {TICK_W{1'b0}};
                    bit_cnt_d  = {BIT_W{1'b0}};
                    state_d    = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    if (tick_cnt_q == MID_TICK) begin
                        tick_cnt_d = {TICK_W{1'b0}};
                        state_d    = rx_s ? S_IDLE : S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_START;
                end
            end
            S_DATA: begin
                if (tick_s) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = {TICK_W{1'b0}};
                        shift_d    = {rx_s, shift_q[n-1:1]};
                        if (bit_cnt_q == LAST_BIT) begin
                            bit_cnt_d = {BIT_W{1'b0}};
                            state_d   = par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_PARITY: begin
                if (tick_s) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = {TICK_W{1'b0}};
                        par_ok_d   = (((^shift_q) ^ rx_s) == par_type_q);
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_PARITY;
                end
            end
            S_STOP: begin
                if (tick_s) begin
                    if (tick_cnt_q == LAST_TICK) begin
                        tick_cnt_d = {TICK_W{1'b0}};
                        if (rx_s) begin
                            data_d    = shift_q;
                            valid_d   = 1'b1;
                            correct_d = par_en_q ? par_ok_q : 1'b1;
                            state_d   = S_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = S_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end else begin
                    state_d = S_STOP;
                end
            end
            S_BREAK: begin
                state_d = rx_s ? S_IDLE : S_BREAK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        idle_d = (state_d == S_IDLE);
    end

    // State, synchroniser and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            rx_prev_q  <= 1'b1;
            div_cnt_q  <= {DIV_W{1'b0}};
            tick_cnt_q <= {TICK_W{1'b0}};
            bit_cnt_q  <= {BIT_W{1'b0}};
            shift_q    <= {n{1'b0}};
            sel_q      <= 3'd0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_ok_q   <= 1'b0;
            data_q     <= {n{1'b0}};
            valid_q    <= 1'b0;
            correct_q  <= 1'b0;
            ferr_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync1_q    <= Rx;
            sync2_q    <= sync1_q;
            rx_prev_q  <= sync2_q;
            div_cnt_q  <= div_cnt_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            sel_q      <= sel_d;
            par_en_q   <= par_en_d;
            par_type_q <= par_type_d;
            par_ok_q   <= par_ok_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            correct_q  <= correct_d;
            ferr_q     <= ferr_d;
            idle_q     <= idle_d;
        end
    end

    assign recive_msg_content = data_q;
    assign valid              = valid_q;
    assign correct            = correct_q;
    assign framing_err        = ferr_q;
    assign Rx_idle            = idle_q;
endmodule
